sv39_unified_tlb: RTL
=====================

Name: sv39_unified_tlb

Overview:
- Parametrised, fully associative Sv39 TLB. One entry array holds 4K, 2M and 1G pages plus error entries; each entry carries a page-size tag.
- Adds ASID tagging, global-page handling, selective SFENCE.VMA-style flush, hardware replacement and a registered one-cycle lookup.
- Sits between the fetch/LSU address stage and the page-table walker. The walker drives the update port after a walk completes.

Parameters:
- ENTRIES, 16, number of entries; power of two, 4..64.
- ASID_W, 16, ASID width; 0 to 16 allowed (0 means no ASID compare).
- PPN2_W, 26, width of the PPN[2] field.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  reset, asynchronous, active-high
- access_valid_i  in  1  lookup request
- access_vpn_i  in  27  VPN[26:0] for lookup
- access_asid_i  in  ASID_W  current satp.ASID
- access_valid_o  out  1  lookup result valid, one cycle after request
- access_miss_o  out  1  no entry matched
- access_multihit_o  out  1  more than one entry matched
- access_error_o  out  1  matched an error entry
- access_pte_o  out  8  PTE flags [7:0] (D A G U X W R V)
- access_ppn2_o  out  PPN2_W  translated PPN[2]
- access_ppn1_o  out  9  translated PPN[1]
- access_ppn0_o  out  9  translated PPN[0]
- update_valid_i  in  1  write request
- update_errpage_i  in  1  1 = write an error entry (PPN/PTE ignored)
- update_pagesize_i  in  2  `SV39_PAGESIZE_KILO / _MEGA / _GIGA
- update_vpn_i  in  27  VPN to install
- update_asid_i  in  ASID_W  ASID to install
- update_ppn2_i  in  PPN2_W  PPN[2]
- update_ppn1_i  in  9  PPN[1]
- update_ppn0_i  in  9  PPN[0]
- update_pte_i  in  8  PTE flags
- flush_i  in  1  flush request
- flush_vpn_en_i  in  1  flush is restricted by VPN
- flush_asid_en_i  in  1  flush is restricted by ASID
- flush_vpn_i  in  27  VPN for a restricted flush
- flush_asid_i  in  ASID_W  ASID for a restricted flush

Behaviour:
- Reset: all entry valid bits 0, replacement pointer 0, every output 0.
- Entry fields: valid, err, size, vpn[26:0], asid, ppn2, ppn1, ppn0, pte.
- Tag compare by size:
  - KILO compares vpn[26:0].
  - MEGA compares vpn[26:9].
  - GIGA compares vpn[26:18].
- ASID rule: ASID matches if pte[5] (G) = 1, or entry asid == access_asid_i. Error entries always compare ASID.
- Lookup (1-cycle latency): hits are computed combinationally from the array in cycle N and registered. The result appears in cycle N+1 with access_valid_o = 1. When access_valid_o = 0, all result outputs are 0.
- Result priority:
  - 0 hits: miss = 1.
  - 2 or more hits (error entries included): multihit = 1, miss = 0, payload = 0.
  - 1 hit on an error entry: error = 1, payload = 0.
  - 1 hit on a KILO entry: stored PPN2/PPN1/PPN0.
  - 1 hit on a MEGA entry: stored PPN2/PPN1, ppn0 = vpn[8:0] of the request.
  - 1 hit on a GIGA entry: stored PPN2, ppn1 = vpn[17:9], ppn0 = vpn[8:0].
  - pte is the stored value on any single non-error hit.
- Update (takes effect at the clock edge): victim selection, in order:
  1. An existing valid entry with identical size, tag and ASID (error or not) is overwritten in place. This prevents self-created multihit.
  2. Otherwise the lowest-index invalid entry.
  3. Otherwise the entry at the round-robin pointer; the pointer then increments, wrapping from ENTRIES-1 to 0.
  - The pointer changes only in case 3.
- Flush (takes effect at the clock edge); an entry is invalidated when:
  - vpn_en = 0, asid_en = 0: all entries.
  - asid_en only: entry asid == flush_asid_i and G = 0.
  - vpn_en only: entry tag covers flush_vpn_i under its own size.
  - both: tag covers flush_vpn_i, asid matches and G = 0.
  - Error entries are treated as G = 0.
- Simultaneous events:
  - Lookup and update in the same cycle: the lookup sees pre-update contents.
  - Flush and update in the same cycle: flush wins and the update is discarded.
  - Flush and lookup in the same cycle: access_valid_o = 0 in the next cycle.
- Reset asserted mid-operation clears the array and any pending result immediately.

Test Plan:
- Reset, then lookup vpn 0x1234567 -> next cycle: valid = 1, miss = 1, multihit = 0, error = 0, payload 0.
- Install MEGA vpn 0x2AAAA00, ppn2 = 0x5, ppn1 = 0x11, pte = 0xCF, asid 3; lookup vpn 0x2AAAA7F, asid 3 -> ppn2 = 0x5, ppn1 = 0x11, ppn0 = 0x07F, pte = 0xCF. Same lookup with asid 4 -> miss.
- Install GIGA vpn 0x4000000 with G = 1 and KILO vpn 0x4000001 (asid 1); lookup vpn 0x4000001, asid 1 -> multihit = 1. Reinstall the KILO entry with the same key -> still exactly 2 valid entries, not 3.
- Fill all 16 entries, then install 3 more -> entries 0, 1, 2 replaced in order; pointer = 3; the original entry-0 VPN now misses.
- Flush with asid_en = 1, asid 3, when entries {asid 3 G = 0, asid 3 G = 1, asid 5} are present -> only the first is invalidated.
- Assert flush_i together with update_valid_i and access_valid_i -> update not installed; access_valid_o = 0 next cycle. Error entry installed then looked up -> error = 1, miss = 0.

Source files
------------

// File: rtl/sv39_unified_tlb.sv
// Fully associative Sv39 TLB holding 4K/2M/1G and error entries in one array.
// Lookup result is registered one cycle after the request. Page size codes: 0 = KILO, 1 = MEGA, 2 = GIGA.
`ifndef SV39_PAGESIZE_KILO
`define SV39_PAGESIZE_KILO 2'd0
`endif
`ifndef SV39_PAGESIZE_MEGA
`define SV39_PAGESIZE_MEGA 2'd1
`endif
`ifndef SV39_PAGESIZE_GIGA
`define SV39_PAGESIZE_GIGA 2'd2
`endif

module sv39_tlb_entry_cmp #(
    parameter int ASID_W = 16
) (
    input  logic                                  ent_valid,
    input  logic                                  ent_err,
    input  logic [1:0]                            ent_size,
    input  logic [26:0]                           ent_vpn,
    input  logic [((ASID_W > 0) ? ASID_W : 1)-1:0] ent_asid,
    input  logic                                  ent_g,
    input  logic [26:0]                           access_vpn,
    input  logic [((ASID_W > 0) ? ASID_W : 1)-1:0] access_asid,
    input  logic [1:0]                            update_size,
    input  logic [26:0]                           update_vpn,
    input  logic [((ASID_W > 0) ? ASID_W : 1)-1:0] update_asid,
    input  logic                                  flush_vpn_en,
    input  logic                                  flush_asid_en,
    input  logic [26:0]                           flush_vpn,
    input  logic [((ASID_W > 0) ? ASID_W : 1)-1:0] flush_asid,
    output logic                                  lookup_hit,
    output logic                                  update_same,
    output logic                                  flush_hit
);
    localparam bit USE_ASID = (ASID_W > 0);

    function automatic logic tag_eq(input logic [1:0] size, input logic [26:0] a, input logic [26:0] b);
        case (size)
            `SV39_PAGESIZE_MEGA: tag_eq = (a[26:9] == b[26:9]);
            `SV39_PAGESIZE_GIGA: tag_eq = (a[26:18] == b[26:18]);
            default:             tag_eq = (a == b);
        endcase
    endfunction

    logic g_eff;
    logic acc_asid_eq, upd_asid_eq, fl_asid_eq;

    // Error entries never behave as global.
    assign g_eff       = ent_g & ~ent_err;
    assign acc_asid_eq = !USE_ASID || (ent_asid == access_asid);
    assign upd_asid_eq = !USE_ASID || (ent_asid == update_asid);
    assign fl_asid_eq  = !USE_ASID || (ent_asid == flush_asid);

    assign lookup_hit  = ent_valid & tag_eq(ent_size, ent_vpn, access_vpn) & (g_eff | acc_asid_eq);
    assign update_same = ent_valid & (ent_size == update_size) &
                         tag_eq(update_size, ent_vpn, update_vpn) & upd_asid_eq;
    assign flush_hit   = ent_valid &
                         (!flush_vpn_en || tag_eq(ent_size, ent_vpn, flush_vpn)) &
                         (!flush_asid_en || (fl_asid_eq && !g_eff));
endmodule

module sv39_unified_tlb #(
    parameter int ENTRIES = 16,
    parameter int ASID_W  = 16,
    parameter int PPN2_W  = 26
) (
    input  logic                                  clk_i,
    input  logic                                  arst_i,
    input  logic                                  access_valid_i,
    input  logic [26:0]                           access_vpn_i,
    input  logic [((ASID_W > 0) ? ASID_W : 1)-1:0] access_asid_i,
    output logic                                  access_valid_o,
    output logic                                  access_miss_o,
    output logic                                  access_multihit_o,
    output logic                                  access_error_o,
    output logic [7:0]                            access_pte_o,
    output logic [PPN2_W-1:0]                     access_ppn2_o,
    output logic [8:0]                            access_ppn1_o,
    output logic [8:0]                            access_ppn0_o,
    input  logic                                  update_valid_i,
    input  logic                                  update_errpage_i,
    input  logic [1:0]                            update_pagesize_i,
    input  logic [26:0]                           update_vpn_i,
    input  logic [((ASID_W > 0) ? ASID_W : 1)-1:0] update_asid_i,
    input  logic [PPN2_W-1:0]                     update_ppn2_i,
    input  logic [8:0]                            update_ppn1_i,
    input  logic [8:0]                            update_ppn0_i,
    input  logic [7:0]                            update_pte_i,
    input  logic                                  flush_i,
    input  logic                                  flush_vpn_en_i,
    input  logic                                  flush_asid_en_i,
    input  logic [26:0]                           flush_vpn_i,
    input  logic [((ASID_W > 0) ? ASID_W : 1)-1:0] flush_asid_i
);
    localparam int AW = (ASID_W > 0) ? ASID_W : 1;
    localparam int IW = $clog2(ENTRIES);

    typedef struct packed {
        logic              err;
        logic [1:0]        size;
        logic [26:0]       vpn;
        logic [AW-1:0]     asid;
        logic [PPN2_W-1:0] ppn2;
        logic [8:0]        ppn1;
        logic [8:0]        ppn0;
        logic [7:0]        pte;
    } tlb_entry_t;

    tlb_entry_t         ent_q [ENTRIES];
    logic [ENTRIES-1:0] ent_vld;
    logic [IW-1:0]      rr_ptr_q;

    logic [ENTRIES-1:0] lk_hit, upd_same, fl_hit;

    for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
        sv39_tlb_entry_cmp #(.ASID_W(ASID_W)) u_cmp (
            .ent_valid     (ent_vld[e]),
            .ent_err       (ent_q[e].err),
            .ent_size      (ent_q[e].size),
            .ent_vpn       (ent_q[e].vpn),
            .ent_asid      (ent_q[e].asid),
            .ent_g         (ent_q[e].pte[5]),
            .access_vpn    (access_vpn_i),
            .access_asid   (access_asid_i),
            .update_size   (update_pagesize_i),
            .update_vpn    (update_vpn_i),
            .update_asid   (update_asid_i),
            .flush_vpn_en  (flush_vpn_en_i),
            .flush_asid_en (flush_asid_en_i),
            .flush_vpn     (flush_vpn_i),
            .flush_asid    (flush_asid_i),
            .lookup_hit    (lk_hit[e]),
            .update_same   (upd_same[e]),
            .flush_hit     (fl_hit[e])
        );
    end

    // Only a single hit feeds the payload, so OR-reducing masked fields is a mux.
    logic              sel_err;
    logic [1:0]        sel_size;
    logic [PPN2_W-1:0] sel_ppn2;
    logic [8:0]        sel_ppn1, sel_ppn0;
    logic [7:0]        sel_pte;

    always_comb begin
        sel_err  = 1'b0;
        sel_size = '0;
        sel_ppn2 = '0;
        sel_ppn1 = '0;
        sel_ppn0 = '0;
        sel_pte  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lk_hit[i]) begin
                sel_err  = sel_err  | ent_q[i].err;
                sel_size = sel_size | ent_q[i].size;
                sel_ppn2 = sel_ppn2 | ent_q[i].ppn2;
                sel_ppn1 = sel_ppn1 | ent_q[i].ppn1;
                sel_ppn0 = sel_ppn0 | ent_q[i].ppn0;
                sel_pte  = sel_pte  | ent_q[i].pte;
            end
        end
    end

    logic any_hit, multi_hit, res_ok, res_err, is_mega, is_giga;
    assign any_hit   = |lk_hit;
    assign multi_hit = |(lk_hit & (lk_hit - ENTRIES'(1)));
    assign res_ok    = any_hit & ~multi_hit & ~sel_err;
    assign res_err   = any_hit & ~multi_hit & sel_err;
    assign is_mega   = (sel_size == `SV39_PAGESIZE_MEGA);
    assign is_giga   = (sel_size == `SV39_PAGESIZE_GIGA);

    // Victim: same-key entry, else lowest free slot, else round-robin pointer.
    logic          same_found, free_found, use_ptr;
    logic [IW-1:0] same_idx, free_idx, victim;

    always_comb begin
        same_found = 1'b0;
        same_idx   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (upd_same[i]) begin
                same_found = 1'b1;
                same_idx   = IW'(i);
            end
            if (!ent_vld[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign use_ptr = ~same_found & ~free_found;
    assign victim  = same_found ? same_idx : (free_found ? free_idx : rr_ptr_q);

    tlb_entry_t upd_ent;
    always_comb begin
        upd_ent      = '0;
        upd_ent.err  = update_errpage_i;
        upd_ent.size = update_pagesize_i;
        upd_ent.vpn  = update_vpn_i;
        upd_ent.asid = update_asid_i;
        if (!update_errpage_i) begin
            upd_ent.ppn2 = update_ppn2_i;
            upd_ent.ppn1 = update_ppn1_i;
            upd_ent.ppn0 = update_ppn0_i;
            upd_ent.pte  = update_pte_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ent_vld  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
        end else if (flush_i) begin
            ent_vld <= ent_vld & ~fl_hit;
        end else if (update_valid_i) begin
            ent_vld[victim] <= 1'b1;
            ent_q[victim]   <= upd_ent;
            if (use_ptr) rr_ptr_q <= rr_ptr_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            access_valid_o    <= 1'b0;
            access_miss_o     <= 1'b0;
            access_multihit_o <= 1'b0;
            access_error_o    <= 1'b0;
            access_pte_o      <= '0;
            access_ppn2_o     <= '0;
            access_ppn1_o     <= '0;
            access_ppn0_o     <= '0;
        end else if (access_valid_i && !flush_i) begin
            access_valid_o    <= 1'b1;
            access_miss_o     <= ~any_hit;
            access_multihit_o <= multi_hit;
            access_error_o    <= res_err;
            access_pte_o      <= res_ok ? sel_pte : '0;
            access_ppn2_o     <= res_ok ? sel_ppn2 : '0;
            access_ppn1_o     <= !res_ok ? '0 : (is_giga ? access_vpn_i[17:9] : sel_ppn1);
            access_ppn0_o     <= !res_ok ? '0 : ((is_mega || is_giga) ? access_vpn_i[8:0] : sel_ppn0);
        end else begin
            access_valid_o    <= 1'b0;
            access_miss_o     <= 1'b0;
            access_multihit_o <= 1'b0;
            access_error_o    <= 1'b0;
            access_pte_o      <= '0;
            access_ppn2_o     <= '0;
            access_ppn1_o     <= '0;
            access_ppn0_o     <= '0;
        end
    end
endmodule
